// File: rtl/reg_file_pkg.sv
// Shared configuration for the reg_file_sb register file: default geometry,
// the address-width helper and the read-port array types.
package reg_file_pkg;

  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_RD        = 4;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  // Address bits needed to index 'depth' registers (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [DEFAULT_WIDTH-1:0] word_t;
  typedef logic [DEFAULT_AW-1:0]    addr_t;

  // One entry per read port, for the default register-file geometry.
  typedef addr_t [MAX_RD-1:0] rd_addr_arr_t;
  typedef word_t [MAX_RD-1:0] rd_data_arr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard for reg_file_sb: tracks which registers await a
// long-latency writeback, answers issue_ready and keeps a registered count.
// With REG_FILE_BYPASS_EN defined, a writeback landing this cycle hides the
// pending bit on matching read ports.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic                 clr_valid,
  input  logic [AW-1:0]        clr_addr,
  input  logic                 flush,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic                 issue_ready,
  output logic [NUM_RD-1:0]    rpend,
  output logic [AW:0]          pend_cnt
);

  localparam logic [AW:0] CNT_ONE = 1;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_next;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_next;
  logic             w_rd_is_zero;
  logic             w_same_reg;
  logic             w_set;
  logic             w_set_new;
  logic             w_clr;

  assign issue_ready  = ~r_pend[issue_rd];
  assign w_rd_is_zero = (ZERO_REG != 0) && (issue_rd == '0);
  assign w_same_reg   = clr_valid && (clr_addr == issue_rd);

  // An issue is taken when the register is free, or when its writeback lands
  // on this very edge (the new producer then owns the register: set wins).
  assign w_set     = issue_valid && !flush && !w_rd_is_zero && (issue_ready || w_same_reg);
  assign w_set_new = w_set && issue_ready;
  assign w_clr     = clr_valid && r_pend[clr_addr] && !(w_set && w_same_reg);

  // Next pending vector and count; flush clears everything and beats issue.
  always_comb begin
    w_pend_next = r_pend;
    w_cnt_next  = r_cnt;
    if (flush) begin
      w_pend_next = '0;
      w_cnt_next  = '0;
    end else begin
      if (w_clr) begin
        w_pend_next[clr_addr] = 1'b0;
        w_cnt_next            = w_cnt_next - CNT_ONE;
      end
      if (w_set) begin
        w_pend_next[issue_rd] = 1'b1;
      end
      if (w_set_new) begin
        w_cnt_next = w_cnt_next + CNT_ONE;
      end
    end
  end

  // Pending bits and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_next;
      r_cnt  <= w_cnt_next;
    end
  end

  assign pend_cnt = r_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rpend
      logic [AW-1:0] w_ra;
      logic          w_p;
      assign w_ra = raddr[gi*AW +: AW];
      // Pending bit seen by read port gi.
      always_comb begin
        w_p = r_pend[w_ra];
`ifdef REG_FILE_BYPASS_EN
        if (clr_valid && (clr_addr == w_ra)) w_p = 1'b0;
`endif
      end
      assign rpend[gi] = w_p;
    end
  endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read register file with a pipeline write port (we0), a long-latency
// writeback port (we1) and a pending-bit scoreboard. we0 wins a same-address
// collision and raises a one-cycle wr_conflict pulse.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write data
// (port 0 first) onto matching read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]       rpend,
  input  logic                    we0,
  input  logic [AW-1:0]           waddr0,
  input  logic [WIDTH-1:0]        wdata0,
  input  logic                    we1,
  input  logic [AW-1:0]           waddr1,
  input  logic [WIDTH-1:0]        wdata1,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  output logic                    issue_ready,
  input  logic                    flush,
  output logic [AW:0]             pend_cnt,
  output logic                    wr_conflict
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_wr_conflict;
  logic             w_we0_eff;
  logic             w_we1_eff;

  // Writes to the hardwired zero register are dropped, and nothing is
  // written or forwarded while reset is held.
  assign w_we0_eff = we0 && reset_n && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w_we1_eff = we1 && reset_n && !((ZERO_REG != 0) && (waddr1 == '0));

  // Register storage; the later we0 assignment gives it priority over we1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_we1_eff) r_mem[waddr1] <= wdata1;
      if (w_we0_eff) r_mem[waddr0] <= wdata0;
    end
  end

  // One-cycle pulse after both ports wrote the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wr_conflict <= 1'b0;
    else          r_wr_conflict <= w_we0_eff && w_we1_eff && (waddr0 == waddr1);
  end

  assign wr_conflict = r_wr_conflict;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]    w_ra;
      logic [WIDTH-1:0] w_rd;
      assign w_ra = raddr[gi*AW +: AW];
      // Combinational read for port gi, with optional write forwarding.
      always_comb begin
        w_rd = r_mem[w_ra];
`ifdef REG_FILE_BYPASS_EN
        if (w_we0_eff && (waddr0 == w_ra))      w_rd = wdata0;
        else if (w_we1_eff && (waddr1 == w_ra)) w_rd = wdata1;
`endif
        if ((ZERO_REG != 0) && (w_ra == '0)) w_rd = '0;
      end
      assign rdata[gi*WIDTH +: WIDTH] = w_rd;
    end
  endgenerate

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clr_valid   (w_we1_eff),
    .clr_addr    (waddr1),
    .flush       (flush),
    .raddr       (raddr),
    .issue_ready (issue_ready),
    .rpend       (rpend),
    .pend_cnt    (pend_cnt)
  );

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of registers (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-003 SHALL have parameter NUM_RD, default 3, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, where 1 makes register 0 hardwired to zero and never pending.
REQ-005 SHALL have port clk, input, 1, clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port raddr, input, NUM_RD x log2(DEPTH), read addresses.
REQ-008 SHALL have port rdata, output, NUM_RD x WIDTH, read data.
REQ-009 SHALL have port rpend, output, NUM_RD, pending bit of each addressed register.
REQ-010 SHALL have ports we0/waddr0/wdata0, input, 1/log2(DEPTH)/WIDTH, single-cycle pipeline write port.
REQ-011 SHALL have ports we1/waddr1/wdata1, input, 1/log2(DEPTH)/WIDTH, long-latency writeback port.
REQ-012 SHALL have ports issue_valid/issue_rd, input, 1/log2(DEPTH), mark destination pending.
REQ-013 SHALL have port issue_ready, output, 1, low when issue_rd is already pending.
REQ-014 SHALL have port flush, input, 1, clear all pending bits.
REQ-015 SHALL have port pend_cnt, output, log2(DEPTH)+1, registered count of pending registers.
REQ-016 SHALL have port wr_conflict, output, 1, registered one-cycle pulse on same-address dual write.

Function
REQ-017 SHALL read combinationally; a write becomes visible on rdata the cycle after the clock edge that performs it (unless bypass is enabled).
REQ-018 SHALL, with ZERO_REG=1, ignore writes and issues to register 0, return 0 for it, drive rpend=0 for it, and keep issue_ready=1 for it.
REQ-019 SHALL, when we0 and we1 target the same address in one cycle, store wdata0 and pulse wr_conflict high the next cycle.
REQ-020 SHALL set a register's pending bit on the edge where issue_valid&issue_ready holds; issue with issue_ready=0 SHALL be ignored.
REQ-021 SHALL clear a register's pending bit on a we1 write to it; we0 SHALL NOT change pending bits.
REQ-022 SHALL, on simultaneous issue and we1 clear of the same register, leave that register pending (set wins).
REQ-023 SHALL, on flush, clear every pending bit and set pend_cnt=0 in the same edge; flush SHALL override a coincident issue, while writes still occur.
REQ-024 SHALL update pend_cnt every edge by +1 per accepted set and -1 per effective clear; it SHALL never underflow or exceed DEPTH.
REQ-025 SHALL drive issue_ready combinationally as NOT(pending[issue_rd]), independent of issue_valid.

Reset
REQ-026 SHALL, while reset_n=0, clear all registers to 0 and all pending bits to 0, and drive pend_cnt=0 and wr_conflict=0.
REQ-027 SHALL, on reset assertion mid-operation, discard in-flight writes and issues of that cycle.

Configuration
REQ-028 SHALL, with macro REG_FILE_BYPASS_EN defined, forward same-cycle write data to matching read ports (port 0 over port 1, register 0 excluded) and drive rpend=0 when a matching we1 is present.
REQ-029 SHALL, without REG_FILE_BYPASS_EN, present only stored register contents and stored pending bits.

Structure
REQ-030 SHALL place the DEPTH/WIDTH defaults, the address-width function and the read-port array typedefs in package reg_file_pkg.
REQ-031 SHALL implement pending bits, issue_ready and pend_cnt in sub-module rf_scoreboard.

Verification
REQ-032 SHALL cover: we0 x5=0xDEADBEEF, read x5 next cycle -> 0xDEADBEEF; read in same cycle -> old value (bypass off) or 0xDEADBEEF (bypass on).
REQ-033 SHALL cover: we0 x0=0x1234, issue x0 -> rdata=0, rpend=0, issue_ready=1, pend_cnt unchanged.
REQ-034 SHALL cover: issue x7, then reissue x7 -> issue_ready=0 and pend_cnt=1; then we1 x7=0x55 -> rpend=0 and pend_cnt=0.
REQ-035 SHALL cover: issue x3 and we1 x3 in the same cycle while x3 is pending -> x3 stays pending and pend_cnt unchanged.
REQ-036 SHALL cover: we0 and we1 both to x9 (0xA, 0xB) -> x9=0xA and wr_conflict=1 for exactly one cycle.
REQ-037 SHALL cover: 4 registers pending, then flush plus issue x2 -> pend_cnt=0; separately, reset_n pulse -> all registers read 0.
